// File: rtl/split_result_collector_pkg.sv
// Shared definitions for the split result collector slice.
// Holds the collector state encoding and the default widths used by the
// interface, the saturating counter and the top module.
package split_pkg;

  localparam int NUM_SPLITS_DEF = 9;
  localparam int CAND_W_DEF     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/split_result_collector_if.sv
// Candidate result handshake between the per-split checkers and the
// collector.
//   in_valid : producer has a candidate result on in_x
//   in_ready : collector takes in_x this cycle
//   in_x     : one result bit per split, bit i from split_i
// master = producer side (checkers), slave = collector side.
interface split_result_collector_if
  import split_pkg::*;
#(
  parameter int NUM_SPLITS = NUM_SPLITS_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_SPLITS-1:0] in_x;

  modport master (
    output in_valid,
    output in_x,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_x,
    output in_ready
  );

endinterface

// File: rtl/split_result_collector_sat_counter.sv
// Saturating up-counter used for the satisfying-candidate count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : add one unless already all-ones
//   count      : current value
//   all_ones   : count has saturated
module split_sat_counter
  import split_pkg::*;
#(
  parameter int W = CAND_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         all_ones
);

  assign all_ones = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !all_ones) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/split_result_collector.sv
// Collects one result vector per candidate from the split checkers, decides
// whether the candidate satisfies every split, and summarises a job of
// num_cand candidates started by a start pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : job start, honoured only in IDLE
//   num_cand   : candidate count, sampled on an accepted start
//   in_bus     : valid/ready/x handshake from the checkers (slave side)
//   busy       : job running
//   done       : one-cycle pulse when the job ends
//   sat_found  : at least one satisfying candidate in this job
//   sat_idx    : index of the first satisfying candidate
//   sat_count  : satisfying candidates, saturating
//   fail_mask  : sticky OR of ~in_x over accepted candidates
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for start, previous results held
// RUN     | accepting candidates, busy and in_ready high
// DONE    | single cycle, done pulse, results final
module split_result_collector
  import split_pkg::*;
#(
  parameter int NUM_SPLITS    = NUM_SPLITS_DEF,
  parameter int CAND_W        = CAND_W_DEF,
  parameter bit STOP_ON_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CAND_W-1:0]     num_cand,
  split_result_collector_if.slave in_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_found,
  output logic [CAND_W-1:0]     sat_idx,
  output logic [CAND_W-1:0]     sat_count,
  output logic [NUM_SPLITS-1:0] fail_mask
);

  state_t state_q, state_d;

  logic              ready_int;
  logic              job_start;
  logic              accept;
  logic              all_sat;
  logic              last_cand;
  logic              sat_count_full;
  logic [CAND_W-1:0] cand_idx;
  logic [CAND_W-1:0] target;

  assign job_start = (state_q == ST_IDLE) && start;
  // Derived straight from the state so the handshake has no comb loop.
  assign accept    = in_bus.in_valid && (state_q == ST_RUN);
  assign all_sat   = &in_bus.in_x;
  assign last_cand = (cand_idx == target - CAND_W'(1));

  assign in_bus.in_ready = ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    ready_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_cand == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        ready_int = 1'b1;
        if (accept && (last_cand || (STOP_ON_FIRST && all_sat))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_idx  <= '0;
      target    <= '0;
      sat_found <= 1'b0;
      sat_idx   <= '0;
      fail_mask <= '0;
    end else if (job_start) begin
      cand_idx  <= '0;
      target    <= num_cand;
      sat_found <= 1'b0;
      sat_idx   <= '0;
      fail_mask <= '0;
    end else if (accept) begin
      fail_mask <= fail_mask | ~in_bus.in_x;
      if (all_sat && !sat_found) begin
        sat_found <= 1'b1;
        sat_idx   <= cand_idx;
      end
      cand_idx <= cand_idx + CAND_W'(1);
    end
  end

  split_sat_counter #(
    .W (CAND_W)
  ) u_sat_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (job_start),
    .inc      (accept && all_sat && !sat_count_full),
    .count    (sat_count),
    .all_ones (sat_count_full)
  );

endmodule

// File: tb/tb_split_result_collector.sv
module tb_split_result_collector;
  import split_pkg::*;

  localparam int NS = 9;
  localparam int CW = 32;
  localparam logic [NS-1:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_cand = '0;

  split_result_collector_if #(.NUM_SPLITS(NS)) bus0 ();
  split_result_collector_if #(.NUM_SPLITS(NS)) bus1 ();

  logic          busy0, done0, found0, busy1, done1, found1;
  logic [CW-1:0] idx0, cnt0, idx1, cnt1;
  logic [NS-1:0] mask0, mask1;

  split_result_collector #(.NUM_SPLITS(NS), .CAND_W(CW), .STOP_ON_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cand(num_cand), .in_bus(bus0),
    .busy(busy0), .done(done0), .sat_found(found0), .sat_idx(idx0),
    .sat_count(cnt0), .fail_mask(mask0)
  );

  split_result_collector #(.NUM_SPLITS(NS), .CAND_W(CW), .STOP_ON_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cand(num_cand), .in_bus(bus1),
    .busy(busy1), .done(done1), .sat_found(found1), .sat_idx(idx1),
    .sat_count(cnt1), .fail_mask(mask1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [NS-1:0] job_x[$];

  task automatic set_in(input logic v, input logic [NS-1:0] x);
    bus0.in_valid = v; bus0.in_x = x;
    bus1.in_valid = v; bus1.in_x = x;
  endtask

  // Runs one job on both collectors (plain and stop-on-first) from job_x and
  // checks handshake, done timing and results against the job-level rules.
  task automatic run_job(input int n, input int gap_mode, input bit poke, input string name);
    int first, cnt, n1, a0, a1, k, cyc;
    bit run0, run1, d0, d1, v, acc0, acc1;
    logic [NS-1:0] m0, m1, x;
    logic [CW-1:0] e_idx, e_cnt0, e_cnt1;
    first = -1; cnt = 0; m0 = '0; m1 = '0;
    for (int i = 0; i < n; i++) begin
      x = job_x[i];
      if (x == ALL1) begin cnt++; if (first < 0) first = i; end
      m0 |= ~x;
    end
    n1 = (first >= 0) ? first + 1 : n;
    for (int i = 0; i < n1; i++) m1 |= ~job_x[i];
    e_idx  = (first >= 0) ? CW'(first) : '0;
    e_cnt0 = CW'(cnt);
    e_cnt1 = (first >= 0) ? CW'(1) : '0;

    set_in(1'b0, '0);
    start = 1'b1; num_cand = CW'(n);
    @(posedge clk); #1;
    start = 1'b0; num_cand = $urandom;
    vectors += 2;
    if ({found0, idx0, cnt0, mask0} !== '0 && n != 0) begin
      miscompares++; $display("FAIL %s clear0: got %0b/%0d/%0d/%h want 0", name, found0, idx0, cnt0, mask0);
    end
    if ({found1, idx1, cnt1, mask1} !== '0 && n != 0) begin
      miscompares++; $display("FAIL %s clear1: got %0b/%0d/%0d/%h want 0", name, found1, idx1, cnt1, mask1);
    end

    if (n == 0) begin
      vectors += 2;
      if ({done0, done1, bus0.in_ready, bus1.in_ready} !== 4'b1100) begin
        miscompares++; $display("FAIL %s empty_done: got %b want 1100", name, {done0, done1, bus0.in_ready, bus1.in_ready});
      end
      if ({found0, idx0, cnt0, mask0, found1, idx1, cnt1, mask1} !== '0) begin
        miscompares++; $display("FAIL %s empty_res: got nonzero results want 0", name);
      end
    end else begin
      run0 = 1'b1; run1 = 1'b1; a0 = 0; a1 = 0; k = 0; cyc = 0;
      while ((run0 || run1) && cyc < 4 * n + 20) begin
        v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
        set_in(v, (k < n) ? job_x[k] : '0);
        if (poke && k == 1) begin start = 1'b1; num_cand = 2; end
        vectors += 2;
        if (bus0.in_ready !== run0 || busy0 !== run0) begin
          miscompares++; $display("FAIL %s ready0: got %b%b want %b", name, bus0.in_ready, busy0, run0);
        end
        if (bus1.in_ready !== run1 || busy1 !== run1) begin
          miscompares++; $display("FAIL %s ready1: got %b%b want %b", name, bus1.in_ready, busy1, run1);
        end
        acc0 = v && run0; acc1 = v && run1;
        @(posedge clk); #1;
        start = 1'b0; cyc++;
        d0 = 1'b0; d1 = 1'b0;
        if (acc0) begin a0++; if (a0 == n)  begin run0 = 1'b0; d0 = 1'b1; end end
        if (acc1) begin a1++; if (a1 == n1) begin run1 = 1'b0; d1 = 1'b1; end end
        if (acc0 || acc1) k++;
        vectors += 2;
        if (done0 !== d0) begin miscompares++; $display("FAIL %s done0 cand %0d: got %b want %b", name, k, done0, d0); end
        if (done1 !== d1) begin miscompares++; $display("FAIL %s done1 cand %0d: got %b want %b", name, k, done1, d1); end
        if (d0) begin
          vectors += 4;
          if (found0 !== (first >= 0)) begin miscompares++; $display("FAIL %s found0: got %b want %b", name, found0, first >= 0); end
          if (idx0 !== e_idx)  begin miscompares++; $display("FAIL %s idx0: got %0d want %0d", name, idx0, e_idx); end
          if (cnt0 !== e_cnt0) begin miscompares++; $display("FAIL %s count0: got %0d want %0d", name, cnt0, e_cnt0); end
          if (mask0 !== m0)    begin miscompares++; $display("FAIL %s mask0: got %h want %h", name, mask0, m0); end
        end
        if (d1) begin
          vectors += 4;
          if (found1 !== (first >= 0)) begin miscompares++; $display("FAIL %s found1: got %b want %b", name, found1, first >= 0); end
          if (idx1 !== e_idx)  begin miscompares++; $display("FAIL %s idx1: got %0d want %0d", name, idx1, e_idx); end
          if (cnt1 !== e_cnt1) begin miscompares++; $display("FAIL %s count1: got %0d want %0d", name, cnt1, e_cnt1); end
          if (mask1 !== m1)    begin miscompares++; $display("FAIL %s mask1: got %h want %h", name, mask1, m1); end
        end
      end
      if (run0 || run1) begin
        vectors++; miscompares++;
        $display("FAIL %s timeout: accepted %0d/%0d want %0d/%0d", name, a0, a1, n, n1);
      end
    end

    // Cycle after done: a start here must be ignored and results must hold.
    start = poke; num_cand = 7;
    set_in(1'b1, ALL1);
    @(posedge clk); #1;
    start = 1'b0;
    set_in(1'b0, '0);
    vectors += 2;
    if ({done0, busy0, bus0.in_ready, found0, idx0, cnt0, mask0} !==
        {3'b000, (first >= 0), e_idx, e_cnt0, m0}) begin
      miscompares++; $display("FAIL %s hold0: got %b%b%b %b/%0d/%0d/%h want 000 %b/%0d/%0d/%h", name,
        done0, busy0, bus0.in_ready, found0, idx0, cnt0, mask0, first >= 0, e_idx, e_cnt0, m0);
    end
    if ({done1, busy1, bus1.in_ready, found1, idx1, cnt1, mask1} !==
        {3'b000, (first >= 0), e_idx, e_cnt1, m1}) begin
      miscompares++; $display("FAIL %s hold1: got %b%b%b %b/%0d/%0d/%h want 000 %b/%0d/%0d/%h", name,
        done1, busy1, bus1.in_ready, found1, idx1, cnt1, mask1, first >= 0, e_idx, e_cnt1, m1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; set_in(1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    vectors += 2;
    if ({busy0, done0, found0, bus0.in_ready, idx0, cnt0, mask0} !== '0) begin
      miscompares++; $display("FAIL reset0: got %b%b%b%b/%0d/%0d/%h want all 0", busy0, done0, found0, bus0.in_ready, idx0, cnt0, mask0);
    end
    if ({busy1, done1, found1, bus1.in_ready, idx1, cnt1, mask1} !== '0) begin
      miscompares++; $display("FAIL reset1: got %b%b%b%b/%0d/%0d/%h want all 0", busy1, done1, found1, bus1.in_ready, idx1, cnt1, mask1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; num_cand = 10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, '0);
      @(posedge clk); #1;
    end
    vectors++;
    if (mask0 !== ALL1 || busy0 !== 1'b1) begin
      miscompares++; $display("FAIL midrun_pre: got busy %b mask %h want 1 %h", busy0, mask0, ALL1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors += 2;
    if ({busy0, done0, found0, bus0.in_ready, idx0, cnt0, mask0} !== '0) begin
      miscompares++; $display("FAIL midrun_rst0: got %b%b%b%b/%0d/%0d/%h want all 0", busy0, done0, found0, bus0.in_ready, idx0, cnt0, mask0);
    end
    if ({busy1, done1, found1, bus1.in_ready, idx1, cnt1, mask1} !== '0) begin
      miscompares++; $display("FAIL midrun_rst1: got %b%b%b%b/%0d/%0d/%h want all 0", busy1, done1, found1, bus1.in_ready, idx1, cnt1, mask1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst_n = 1'b1;
      vectors++;
      if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0) begin
        miscompares++; $display("FAIL midrun_after cyc %0d: got done %b%b busy %b want 000", i, done0, done1, busy0);
      end
    end
    set_in(1'b0, '0);
  endtask

  task automatic test_mixed();
    job_x = '{9'h1FF, 9'h0FF, 9'h1FF, 9'h1FE};
    run_job(4, 0, 1'b0, "mixed");
  endtask

  task automatic test_no_solution();
    job_x = '{9'h1F0, 9'h00F, 9'h1FE};
    run_job(3, 1, 1'b0, "nosol");
  endtask

  task automatic test_empty();
    job_x = {};
    run_job(0, 0, 1'b0, "empty");
  endtask

  task automatic test_stop_on_first();
    job_x = {};
    for (int i = 0; i < 7; i++) job_x.push_back('0);
    job_x.push_back(ALL1);
    for (int i = 8; i < 100; i++) job_x.push_back(NS'($urandom));
    run_job(100, 0, 1'b0, "stop");
  endtask

  task automatic test_start_ignored();
    job_x = '{9'h0F0, 9'h1EF, 9'h17F, 9'h0FF, 9'h1FD};
    run_job(5, 0, 1'b1, "startign");
    job_x = '{9'h1FF, 9'h1FF, 9'h000};
    run_job(3, 0, 1'b0, "restart");
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 12);
      job_x = {};
      for (int i = 0; i < n; i++)
        job_x.push_back(($urandom_range(0, 2) == 0) ? ALL1 : NS'($urandom));
      run_job(n, 2, 1'b0, "random");
    end
  endtask

  initial begin
    set_in(1'b0, '0);
    test_reset();
    test_mixed();
    test_no_solution();
    test_empty();
    test_stop_on_first();
    test_start_ignored();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end

endmodule
